// File: rtl/iob_eth_rst_seq.sv
// Ethernet reset sequencer: PHY reset pulse, PHY settle wait, core reset, then run.
// A rising edge on sw_rst_i while running replays the sequence and keeps the completed-sequence count.
module iob_eth_rst_seq #(
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned PHY_RST_CYCLES  = 1000,
  parameter int unsigned PHY_WAIT_CYCLES = 5000,
  parameter int unsigned CORE_RST_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sw_rst_i,
  output logic       phy_rst_n_o,
  output logic       core_rst_o,
  output logic       busy_o,
  output logic       ready_o,
  output logic [7:0] seq_count_o
);

  localparam int unsigned SEQ_W = 8;

  // Terminal counts: the last cycle of each timed state, never above 2^CNT_W-1.
  localparam logic [CNT_W-1:0] PHY_RST_LAST  = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHY_WAIT_LAST = CNT_W'(PHY_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_RST_LAST = CNT_W'(CORE_RST_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PHY_RST,
    S_PHY_WAIT,
    S_CORE_RST,
    S_RUN
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [SEQ_W-1:0] seq_count_d;
  logic             sw_q;
  logic             sw_edge;
  logic             phy_rst_n_d;
  logic             core_rst_d;
  logic             busy_d;
  logic             ready_d;

  assign sw_edge = sw_rst_i & ~sw_q;

  // Next state, counter and sequence count; outputs are decoded from the next state and registered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seq_count_d = seq_count_o;

    case (state_q)
      S_PHY_RST: begin
        if (cnt_q == PHY_RST_LAST) begin
          cnt_d   = '0;
          state_d = S_PHY_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PHY_WAIT: begin
        if (cnt_q == PHY_WAIT_LAST) begin
          cnt_d   = '0;
          state_d = S_CORE_RST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CORE_RST: begin
        if (cnt_q == CORE_RST_LAST) begin
          cnt_d   = '0;
          state_d = S_RUN;
          if (seq_count_o != '1) begin
            seq_count_d = seq_count_o + SEQ_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        // Software edges outside S_RUN are simply dropped.
        if (sw_edge) begin
          cnt_d   = '0;
          state_d = S_PHY_RST;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_PHY_RST;
      end
    endcase

    phy_rst_n_d = (state_d != S_PHY_RST);
    core_rst_d  = (state_d != S_RUN);
    busy_d      = (state_d != S_RUN);
    ready_d     = (state_d == S_RUN);
  end

  // State, counters and output registers; rst_i has priority over any software edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_PHY_RST;
      cnt_q       <= '0;
      seq_count_o <= '0;
      sw_q        <= 1'b0;
      phy_rst_n_o <= 1'b0;
      core_rst_o  <= 1'b1;
      busy_o      <= 1'b1;
      ready_o     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seq_count_o <= seq_count_d;
      sw_q        <= sw_rst_i;
      phy_rst_n_o <= phy_rst_n_d;
      core_rst_o  <= core_rst_d;
      busy_o      <= busy_d;
      ready_o     <= ready_d;
    end
  end

endmodule
